approx_error_monitor: RTL and testbench

- Sits directly downstream of the approximate adder; consumes its operands and 9-bit sum.
- Computes the exact reference sum and the error distance (ED) for each sample.
- Accumulates error statistics over a fixed window of samples, then reports: error count, max ED, sum of ED.
- Used in simulation and on-chip characterisation of approximate adder variants.

---
 rtl/approx_error_monitor.sv | 256 +++++++++++++++++++++++++
 tb/tb_approx_error_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// ---------------------------------------------------------------------------
// approx_error_monitor
//
// Watches an approximate adder's operands and result. For each accepted
// sample it forms the exact sum and the error distance
// ED = |(X+Y+Cin) - Sum|. It then reports error statistics once per window of
// WINDOW accepted samples.
//
// Optional feature macro: ERR_BIAS_EN
//   - Defined:   bias_acc accumulates the signed (exact - Sum). The sum
//                saturates; it does not wrap.
//   - Undefined: bias_acc is tied to zero and no bias logic is built.
//
// Ports
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         opens a new window from IDLE or DONE
//   in_valid      X/Y/Cin/Sum valid this cycle (accepted only in RUN)
//   X, Y, Cin     adder operands
//   Sum           approximate adder result, WIDTH+1 bits
//   busy          high in RUN and DRAIN
//   done          single-cycle pulse; results are final while it is high
//   sample_count  samples accepted in the current window
//   err_count     samples with ED != 0
//   max_ed        largest ED in the window
//   sum_ed        saturating sum of ED
//   bias_acc      saturating signed sum of (exact - Sum), or 0 when disabled
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; results from the last window are held
//   RUN     | accepting samples until WINDOW of them have been taken
//   DRAIN   | the last sample is still in stage 2; nothing is accepted
//   DONE    | done=1 for one cycle; start re-enters RUN, otherwise go to IDLE
// ---------------------------------------------------------------------------
module approx_error_monitor #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic [WIDTH:0]   Sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic [ACC_W:0]   bias_acc
);

    localparam int EW = WIDTH + 1;
    localparam int DW = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   clear;

    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [EW-1:0]    max_ed_q, max_ed_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;

    logic          s1_valid_q;
    logic [EW-1:0] s1_ed_q;

    logic [EW-1:0]  exact_w;
    logic [DW-1:0]  diff_w;
    logic [EW-1:0]  ed_w;
    logic [ACC_W:0] sum_ext_w;

    // -------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (sample_count_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    // -------------------------------------------------------------------
    // Stage 1: exact sum and error distance
    // -------------------------------------------------------------------
    assign exact_w = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
    // One extra bit keeps the signed difference free of overflow.
    assign diff_w  = {1'b0, exact_w} - {1'b0, Sum};
    assign ed_w    = diff_w[DW-1] ? EW'(-diff_w) : diff_w[EW-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_ed_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_ed_q <= ed_w;
            end
        end
    end

    // -------------------------------------------------------------------
    // Stage 2: statistics
    // -------------------------------------------------------------------
    assign sum_ext_w = {1'b0, sum_ed_q} + (ACC_W + 1)'(s1_ed_q);

    always_comb begin
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        max_ed_d       = max_ed_q;
        sum_ed_d       = sum_ed_q;
        if (clear) begin
            sample_count_d = '0;
            err_count_d    = '0;
            max_ed_d       = '0;
            sum_ed_d       = '0;
        end else begin
            if (accept) begin
                sample_count_d = sample_count_q + CNT_W'(1);
            end
            if (s1_valid_q) begin
                if (s1_ed_q != '0) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (s1_ed_q > max_ed_q) begin
                    max_ed_d = s1_ed_q;
                end
                // A carry out of the accumulator pins it at all ones.
                sum_ed_d = sum_ext_w[ACC_W] ? {ACC_W{1'b1}} : sum_ext_w[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
        end else begin
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            max_ed_q       <= max_ed_d;
            sum_ed_q       <= sum_ed_d;
        end
    end

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;

`ifdef ERR_BIAS_EN
    // -------------------------------------------------------------------
    // Signed bias accumulator, ACC_W+1 bits, saturating
    // -------------------------------------------------------------------
    logic [DW-1:0]    s1_diff_q;
    logic [ACC_W:0]   bias_q, bias_d;
    logic [ACC_W+1:0] bias_ext_w;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_diff_q <= '0;
        end else if (accept) begin
            s1_diff_q <= diff_w;
        end
    end

    // The sum is formed one bit wider than the accumulator. If its top two
    // bits disagree, the result overflowed in the direction of the top bit.
    assign bias_ext_w = {bias_q[ACC_W], bias_q}
                      + {{(ACC_W - WIDTH){s1_diff_q[DW-1]}}, s1_diff_q};

    always_comb begin
        bias_d = bias_q;
        if (clear) begin
            bias_d = '0;
        end else if (s1_valid_q) begin
            if (bias_ext_w[ACC_W+1] != bias_ext_w[ACC_W]) begin
                bias_d = bias_ext_w[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}}
                                             : {1'b0, {ACC_W{1'b1}}};
            end else begin
                bias_d = bias_ext_w[ACC_W:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bias_q <= '0;
        end else begin
            bias_q <= bias_d;
        end
    end

    assign bias_acc = bias_q;
`else
    assign bias_acc = '0;
`endif

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor.
// dut_a uses WINDOW=4 with the default accumulator width.
// dut_b uses WINDOW=3 with ACC_W=10, so that saturation can be reached.
// The two instances share the sample inputs and have separate start inputs.
module tb_approx_error_monitor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] X = 8'h00;
    logic [7:0] Y = 8'h00;
    logic       Cin = 1'b0;
    logic [8:0] Sum = 9'h000;

    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] sc_a, ec_a, sc_b, ec_b;
    logic [8:0]  me_a, me_b;
    logic [23:0] se_a;
    logic [24:0] ba_a;
    logic [9:0]  se_b;
    logic [10:0] ba_b;

    int checks = 0;
    int failures = 0;

`ifdef ERR_BIAS_EN
    localparam logic [10:0] EXP_BIAS_ERR = 11'd3;
    localparam logic [10:0] EXP_BIAS_SAT = 11'd1023;
`else
    localparam logic [10:0] EXP_BIAS_ERR = 11'd0;
    localparam logic [10:0] EXP_BIAS_SAT = 11'd0;
`endif

    approx_error_monitor #(.WIDTH(8), .WINDOW(4), .ACC_W(24), .CNT_W(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .in_valid(in_valid),
        .X(X), .Y(Y), .Cin(Cin), .Sum(Sum),
        .busy(busy_a), .done(done_a), .sample_count(sc_a), .err_count(ec_a),
        .max_ed(me_a), .sum_ed(se_a), .bias_acc(ba_a)
    );

    approx_error_monitor #(.WIDTH(8), .WINDOW(3), .ACC_W(10), .CNT_W(16)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .in_valid(in_valid),
        .X(X), .Y(Y), .Cin(Cin), .Sum(Sum),
        .busy(busy_b), .done(done_b), .sample_count(sc_b), .err_count(ec_b),
        .max_ed(me_b), .sum_ed(se_b), .bias_acc(ba_b)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic [8:0] s);
        in_valid = v; X = x; Y = y; Cin = c; Sum = s;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%0d exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done_a got=%0d exp=0", done_a); end
        checks++; if (sc_a !== 16'd0 || ec_a !== 16'd0) begin failures++; $display("FAIL reset_counts_a got=%0d/%0d exp=0/0", sc_a, ec_a); end
        checks++; if (me_a !== 9'd0 || se_a !== 24'd0 || ba_a !== 25'd0) begin failures++; $display("FAIL reset_stats_a got=%0d/%0d/%0d exp=0/0/0", me_a, se_a, ba_a); end
        checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || sc_b !== 16'd0 || se_b !== 10'd0) begin failures++; $display("FAIL reset_b got busy=%0d done=%0d sc=%0d se=%0d exp=0", busy_b, done_b, sc_b, se_b); end
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL reset_idle got busy=%0d done=%0d exp=0/0", busy_a, done_a); end
    endtask

    task automatic test_exact();
        logic [7:0] xs [4] = '{8'hFF, 8'h11, 8'hFF, 8'h00};
        logic [7:0] ys [4] = '{8'h01, 8'h11, 8'h00, 8'h00};
        logic       cs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] ss [4] = '{9'h100, 9'h022, 9'h100, 9'h000};
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1 || sc_a !== 16'd0) begin failures++; $display("FAIL exact_start got busy=%0d sc=%0d exp=1/0", busy_a, sc_a); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, xs[i], ys[i], cs[i], ss[i]);
            cyc();
            checks++; if (sc_a !== 16'(i + 1)) begin failures++; $display("FAIL exact_sc[%0d] got=%0d exp=%0d", i, sc_a, i + 1); end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL exact_drain got busy=%0d done=%0d exp=1/0", busy_a, done_a); end
        cyc();
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL exact_done got done=%0d busy=%0d exp=1/0", done_a, busy_a); end
        checks++; if (ec_a !== 16'd0 || me_a !== 9'd0 || se_a !== 24'd0 || sc_a !== 16'd4) begin failures++; $display("FAIL exact_stats got ec=%0d me=%0d se=%0d sc=%0d exp=0/0/0/4", ec_a, me_a, se_a, sc_a); end
        cyc();
        checks++; if (done_a !== 1'b0 || sc_a !== 16'd4) begin failures++; $display("FAIL exact_hold got done=%0d sc=%0d exp=0/4", done_a, sc_a); end
    endtask

    task automatic test_errors();
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        drive(1'b1, 8'hFF, 8'h01, 1'b0, 9'h0FF);
        cyc();
        checks++; if (ec_b !== 16'd0) begin failures++; $display("FAIL err_latency1 got=%0d exp=0", ec_b); end
        drive(1'b1, 8'h11, 8'h11, 1'b0, 9'h020);
        cyc();
        checks++; if (ec_b !== 16'd1 || se_b !== 10'd1) begin failures++; $display("FAIL err_latency2 got ec=%0d se=%0d exp=1/1", ec_b, se_b); end
        drive(1'b1, 8'h0F, 8'h01, 1'b0, 9'h010);
        cyc();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        checks++; if (ec_b !== 16'd2 || se_b !== 10'd3 || me_b !== 9'd2 || done_b !== 1'b0) begin failures++; $display("FAIL err_drain got ec=%0d se=%0d me=%0d done=%0d exp=2/3/2/0", ec_b, se_b, me_b, done_b); end
        cyc();
        checks++; if (done_b !== 1'b1 || ec_b !== 16'd2 || me_b !== 9'd2 || se_b !== 10'd3 || sc_b !== 16'd3) begin failures++; $display("FAIL err_done got done=%0d ec=%0d me=%0d se=%0d sc=%0d exp=1/2/2/3/3", done_b, ec_b, me_b, se_b, sc_b); end
        checks++; if (ba_b !== EXP_BIAS_ERR) begin failures++; $display("FAIL err_bias got=%0d exp=%0d", ba_b, EXP_BIAS_ERR); end
        cyc();
    endtask

    task automatic test_saturation();
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        checks++; if (sc_b !== 16'd0 || se_b !== 10'd0 || ec_b !== 16'd0 || me_b !== 9'd0) begin failures++; $display("FAIL sat_clear got sc=%0d se=%0d ec=%0d me=%0d exp=0", sc_b, se_b, ec_b, me_b); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000);
            cyc();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        checks++; if (se_b !== 10'd1022) begin failures++; $display("FAIL sat_partial got=%0d exp=1022", se_b); end
        cyc();
        checks++; if (done_b !== 1'b1 || se_b !== 10'd1023 || me_b !== 9'd511 || ec_b !== 16'd3) begin failures++; $display("FAIL sat_done got done=%0d se=%0d me=%0d ec=%0d exp=1/1023/511/3", done_b, se_b, me_b, ec_b); end
        checks++; if (ba_b !== EXP_BIAS_SAT) begin failures++; $display("FAIL sat_bias got=%0d exp=%0d", ba_b, EXP_BIAS_SAT); end
        cyc();
    endtask

    task automatic test_gapped();
        drive(1'b1, 8'h00, 8'h00, 1'b0, 9'h001);
        cyc();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        cyc();
        cyc();
        checks++; if (sc_a !== 16'd4 || ec_a !== 16'd0 || busy_a !== 1'b0) begin failures++; $display("FAIL gap_idle_ignored got sc=%0d ec=%0d busy=%0d exp=4/0/0", sc_a, ec_a, busy_a); end
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive((i % 2) == 0, 8'h00, 8'h00, 1'b0, 9'h001);
            cyc();
            checks++; if (busy_a !== 1'b1 || done_a !== 1'b0 || sc_a !== 16'(i / 2 + 1)) begin failures++; $display("FAIL gap_run[%0d] got busy=%0d done=%0d sc=%0d exp=1/0/%0d", i, busy_a, done_a, sc_a, i / 2 + 1); end
        end
        drive(1'b1, 8'h00, 8'h00, 1'b0, 9'h001);
        cyc();
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || sc_a !== 16'd4 || ec_a !== 16'd4 || se_a !== 24'd4) begin failures++; $display("FAIL gap_done got done=%0d busy=%0d sc=%0d ec=%0d se=%0d exp=1/0/4/4/4", done_a, busy_a, sc_a, ec_a, se_a); end
        cyc();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b0 || sc_a !== 16'd4 || se_a !== 24'd4) begin failures++; $display("FAIL gap_after got done=%0d busy=%0d sc=%0d se=%0d exp=0/0/4/4", done_a, busy_a, sc_a, se_a); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        drive(1'b1, 8'h00, 8'h00, 1'b0, 9'h001);
        cyc();
        cyc();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        cyc();
        checks++; if (sc_a !== 16'd2 || ec_a !== 16'd2 || busy_a !== 1'b1) begin failures++; $display("FAIL mid_pre got sc=%0d ec=%0d busy=%0d exp=2/2/1", sc_a, ec_a, busy_a); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || sc_a !== 16'd0 || ec_a !== 16'd0 || me_a !== 9'd0 || se_a !== 24'd0 || ba_a !== 25'd0) begin failures++; $display("FAIL mid_async got busy=%0d sc=%0d ec=%0d me=%0d se=%0d ba=%0d exp=0", busy_a, sc_a, ec_a, me_a, se_a, ba_a); end
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (done_a !== 1'b0) done_seen++;
        end
        reset_n = 1'b1;
        cyc();
        if (done_a !== 1'b0 || busy_a !== 1'b0) done_seen++;
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        checks++; if (sc_a !== 16'd0 || busy_a !== 1'b1) begin failures++; $display("FAIL mid_restart got sc=%0d busy=%0d exp=0/1", sc_a, busy_a); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h22, 8'h11, 1'b0, 9'h033);
            cyc();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        cyc();
        checks++; if (done_a !== 1'b1 || sc_a !== 16'd4 || ec_a !== 16'd0) begin failures++; $display("FAIL mid_fresh got done=%0d sc=%0d ec=%0d exp=1/4/0", done_a, sc_a, ec_a); end
        cyc();
    endtask

    task automatic test_restart();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h00, 8'h00, 1'b0, 9'h002);
            cyc();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        start_a = 1'b1;
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL rst_drain got busy=%0d done=%0d exp=1/0", busy_a, done_a); end
        cyc();
        checks++; if (done_a !== 1'b1 || ec_a !== 16'd4 || se_a !== 24'd8 || me_a !== 9'd2) begin failures++; $display("FAIL rst_prev got done=%0d ec=%0d se=%0d me=%0d exp=1/4/8/2", done_a, ec_a, se_a, me_a); end
        cyc();
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0 || sc_a !== 16'd0 || ec_a !== 16'd0 || se_a !== 24'd0 || me_a !== 9'd0) begin failures++; $display("FAIL rst_clear got busy=%0d done=%0d sc=%0d ec=%0d se=%0d me=%0d exp=1/0/0/0/0/0", busy_a, done_a, sc_a, ec_a, se_a, me_a); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h00, 8'h00, 1'b0, 9'h001);
            cyc();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        cyc();
        checks++; if (done_a !== 1'b1 || sc_a !== 16'd4 || se_a !== 24'd4 || me_a !== 9'd1) begin failures++; $display("FAIL rst_second got done=%0d sc=%0d se=%0d me=%0d exp=1/4/4/1", done_a, sc_a, se_a, me_a); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_exact();
        test_errors();
        test_saturation();
        test_gapped();
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
